mem_access_stage: RTL

Pipeline MEM stage of the MIPS core, sitting between the EX stage and the word-addressed data memory (1024 x 32, combinational read, write on posedge when its `op` equals SW). It accepts one load/store per handshake, drives the memory's `op/address/writevalue` port, and handles byte and halfword accesses by lane extraction or read-modify-write. It flags misaligned accesses and delivers registered results to writeback.

---
 rtl/mem_access_stage.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage of the MIPS core. It takes one load/store from EX per
//   handshake and drives a word-addressed data memory that has a
//   combinational read and is written on posedge when op = SW.
//   Byte and halfword loads are handled by lane extraction (big-endian).
//   Byte and halfword stores are done as a read-modify-write.
//   Misaligned accesses raise a one-cycle exception instead of retiring.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   ex_valid/ex_ready            EX handshake
//   ex_op/ex_addr/ex_wdata/ex_rt EX instruction: opcode, byte address, store data, load rd
//   mem_op/mem_addr/mem_wdata    memory request (0x23 read, 0x2B write, 0x00 idle)
//   mem_rdata                    memory read data, combinational on mem_addr
//   wb_valid/wb_we/wb_rd/wb_data registered retirement to writeback
//   exc_valid/exc_addr           registered address-error report
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rt,
  output logic [5:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_addr
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_NONE = 6'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  logic [5:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [4:0]        rt_r;
  logic [31:0]       rword_r;

  logic accept_s;
  logic aligned_s;
  logic is_load_s;
  logic is_rmw_s;
  logic [ADDR_W-1:0] word_addr_s;

  // Extract and extend the addressed lane of a word; byte offset 0 is bits 31:24.
  function automatic logic [31:0] load_extract(input logic [5:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LBU:  res = {24'h000000, b};
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LHU:  res = {16'h0000, h};
      OP_LW:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/halfword lane of a word with store data.
  function automatic logic [31:0] store_merge(input logic [5:0] op,
                                              input logic [1:0] off,
                                              input logic [31:0] word,
                                              input logic [31:0] data);
    logic [31:0] res;
    res = word;
    if (op == OP_SB) begin
      case (off)
        2'd0:    res[31:24] = data[7:0];
        2'd1:    res[23:16] = data[7:0];
        2'd2:    res[15:8]  = data[7:0];
        2'd3:    res[7:0]   = data[7:0];
        default: res = word;
      endcase
    end else if (off[1]) begin
      res[15:0] = data[15:0];
    end else begin
      res[31:16] = data[15:0];
    end
    return res;
  endfunction

  assign accept_s    = ex_valid && ex_ready;
  assign word_addr_s = {addr_r[ADDR_W-1:2], 2'b00};

  // Classify the latched instruction: alignment, load, read-modify-write store.
  always_comb begin
    aligned_s = 1'b1;
    is_load_s = 1'b0;
    case (op_r)
      OP_LB, OP_LBU:        is_load_s = 1'b1;
      OP_LH, OP_LHU: begin
        is_load_s = 1'b1;
        aligned_s = (addr_r[0] == 1'b0);
      end
      OP_SH:                aligned_s = (addr_r[0] == 1'b0);
      OP_LW: begin
        is_load_s = 1'b1;
        aligned_s = (addr_r[1:0] == 2'b00);
      end
      OP_SW:                aligned_s = (addr_r[1:0] == 2'b00);
      default: begin
        aligned_s = 1'b1;
        is_load_s = 1'b0;
      end
    endcase
    // A misaligned SH becomes a single-cycle exception, so it never merges.
    is_rmw_s = aligned_s && ((op_r == OP_SB) || (op_r == OP_SH));
  end

  // Handshake: open in IDLE and in single-cycle ACCESS, closed while reset is high.
  always_comb begin
    ex_ready = 1'b0;
    if (reset) begin
      ex_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE:    ex_ready = 1'b1;
        ACCESS:  ex_ready = !is_rmw_s;
        MERGE:   ex_ready = 1'b0;
        default: ex_ready = 1'b0;
      endcase
    end
  end

  // Memory request. This is combinational so that a reset raised during MERGE
  // cancels the write in the same cycle.
  always_comb begin
    mem_op    = OP_NONE;
    mem_addr  = '0;
    mem_wdata = 32'h0000_0000;
    if (reset) begin
      mem_op = OP_NONE;
    end else begin
      case (state_r)
        ACCESS: begin
          if (aligned_s && (is_load_s || is_rmw_s)) begin
            mem_op   = OP_LW;
            mem_addr = word_addr_s;
          end else if (aligned_s && (op_r == OP_SW)) begin
            mem_op    = OP_SW;
            mem_addr  = word_addr_s;
            mem_wdata = wdata_r;
          end else begin
            mem_op = OP_NONE;
          end
        end
        MERGE: begin
          mem_op    = OP_SW;
          mem_addr  = word_addr_s;
          mem_wdata = store_merge(op_r, addr_r[1:0], rword_r, wdata_r);
        end
        default: mem_op = OP_NONE;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = accept_s ? ACCESS : IDLE;
      ACCESS: begin
        if (is_rmw_s) begin
          state_next_s = MERGE;
        end else if (accept_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      MERGE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register, instruction latch and registered writeback/exception outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      op_r      <= 6'h00;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      rt_r      <= 5'd0;
      rword_r   <= 32'h0000_0000;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0000_0000;
      exc_valid <= 1'b0;
      exc_addr  <= '0;
    end else begin
      state_r   <= state_next_s;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      exc_valid <= 1'b0;
      if (accept_s) begin
        op_r    <= ex_op;
        addr_r  <= ex_addr;
        wdata_r <= ex_wdata;
        rt_r    <= ex_rt;
      end
      if (state_r == ACCESS) begin
        if (is_rmw_s) begin
          rword_r <= mem_rdata;
        end else if (!aligned_s) begin
          exc_valid <= 1'b1;
          exc_addr  <= addr_r;
        end else begin
          wb_valid <= 1'b1;
          wb_we    <= is_load_s && (rt_r != 5'd0);
          wb_rd    <= rt_r;
          if (is_load_s) begin
            wb_data <= load_extract(op_r, addr_r[1:0], mem_rdata);
          end
        end
      end else if (state_r == MERGE) begin
        wb_valid <= 1'b1;
        wb_we    <= 1'b0;
        wb_rd    <= rt_r;
      end
    end
  end

endmodule
